// File: rtl/alien_swarm.sv
// Alien formation tracker: shared origin plus alive matrix, left/right march with
// step-down at the bounds, bullet hit resolution, wave status and a registered scan pixel.
module alien_swarm #(
  parameter int NUM_ROWS      = 3,
  parameter int NUM_COLS      = 5,
  parameter int SPACING_X     = 64,
  parameter int SPACING_Y     = 32,
  parameter int START_X       = 100,
  parameter int START_Y       = 50,
  parameter int ALIEN_W       = 32,
  parameter int ALIEN_H       = 16,
  parameter int LEFT_BOUND    = 16,
  parameter int RIGHT_BOUND   = 624,
  parameter int STEP_X        = 4,
  parameter int STEP_Y        = 16,
  parameter int INVADE_Y      = 400,
  parameter int BASE_PERIOD   = 60,
  parameter int MIN_PERIOD    = 4,
  parameter int KILL_SPEEDUP  = 2,
  parameter int LEVEL_SPEEDUP = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      frame_tick,
  input  logic [9:0]                                scan_x,
  input  logic [9:0]                                scan_y,
  input  logic                                      hit_valid,
  input  logic [9:0]                                hit_x,
  input  logic [9:0]                                hit_y,
  input  logic                                      restart,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0]         alive_matrix,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0]         armed_matrix,
  output logic [9:0]                                origin_x,
  output logic [9:0]                                origin_y,
  output logic [$clog2(NUM_ROWS*NUM_COLS+1)-1:0]    alive_count,
  output logic [3:0]                                level,
  output logic                                      hit_ack,
  output logic                                      hit_miss,
  output logic [2:0]                                hit_row,
  output logic [3:0]                                hit_col,
  output logic                                      wave_cleared,
  output logic                                      invaded,
  output logic                                      alien_pixel,
  output logic [1:0]                                state_dbg
);

  localparam int N  = NUM_ROWS * NUM_COLS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {MARCH = 2'd0, CLEARED = 2'd1, INVADED = 2'd2} state_t;
  state_t state_q, state_d;

  logic [NUM_ROWS-1:0][NUM_COLS-1:0] alive_q, hit_mask;
  logic [10:0] origin_x_q, origin_y_q;
  logic        dir_right_q;
  logic [3:0]  level_q;
  logic [15:0] frame_cnt_q;
  logic [CW-1:0] alive_cnt;
  logic [NUM_COLS-1:0] col_any;
  logic [NUM_ROWS-1:0] row_any;
  int          maxcol, mincol, maxrow, period, killed;
  logic        hit_found, pixel_d, marching, move_fire, step_down, invade_now, hit_take;
  logic [2:0]  hit_r_d;
  logic [3:0]  hit_c_d;
  logic [10:0] right_edge, left_edge, down_y;

  // Occupancy summary, extreme alive row/column and population count.
  always_comb begin
    col_any   = '0;
    row_any   = '0;
    alive_cnt = '0;
    maxcol    = 0;
    mincol    = 0;
    maxrow    = 0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        col_any[c] = col_any[c] | alive_q[r][c];
        row_any[r] = row_any[r] | alive_q[r][c];
        alive_cnt  = alive_cnt + CW'(alive_q[r][c]);
      end
    end
    for (int c = 0; c < NUM_COLS; c++) if (col_any[c]) maxcol = c;
    for (int c = NUM_COLS - 1; c >= 0; c--) if (col_any[c]) mincol = c;
    for (int r = 0; r < NUM_ROWS; r++) if (row_any[r]) maxrow = r;
  end

  // Signed period so heavy losses at high levels clamp to the floor instead of wrapping.
  always_comb begin
    killed = N - int'(alive_cnt);
    period = BASE_PERIOD - killed * KILL_SPEEDUP - int'(level_q) * LEVEL_SPEEDUP;
    if (period < MIN_PERIOD) period = MIN_PERIOD;
  end

  assign marching   = (state_q == MARCH) && (alive_cnt != '0);
  assign move_fire  = frame_tick && marching && (int'(frame_cnt_q) >= period - 1);
  assign right_edge = origin_x_q + 11'(maxcol * SPACING_X) + 11'(ALIEN_W);
  assign left_edge  = origin_x_q + 11'(mincol * SPACING_X);
  assign step_down  = dir_right_q ? ((right_edge + 11'(STEP_X)) > 11'(RIGHT_BOUND))
                                  : (left_edge < 11'(LEFT_BOUND + STEP_X));
  assign down_y     = origin_y_q + 11'(STEP_Y);
  assign invade_now = (down_y + 11'(maxrow * SPACING_Y) + 11'(ALIEN_H)) >= 11'(INVADE_Y);
  assign hit_take   = hit_valid && (state_q == MARCH) && hit_found;

  // Hit search and scan pixel; columns walk downward so the lowest column wins within a row,
  // and later (higher) rows override earlier ones.
  always_comb begin
    logic [10:0] bx, by;
    bx        = '0;
    by        = '0;
    hit_found = 1'b0;
    hit_r_d   = '0;
    hit_c_d   = '0;
    hit_mask  = '0;
    pixel_d   = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = NUM_COLS - 1; c >= 0; c--) begin
        bx = origin_x_q + 11'(c * SPACING_X);
        by = origin_y_q + 11'(r * SPACING_Y);
        if (alive_q[r][c] && ({1'b0, hit_x} >= bx) && ({1'b0, hit_x} < bx + 11'(ALIEN_W)) &&
            ({1'b0, hit_y} >= by) && ({1'b0, hit_y} < by + 11'(ALIEN_H))) begin
          hit_found      = 1'b1;
          hit_r_d        = 3'(r);
          hit_c_d        = 4'(c);
          hit_mask       = '0;
          hit_mask[r][c] = 1'b1;
        end
        if (alive_q[r][c] && ({1'b0, scan_x} >= bx) && ({1'b0, scan_x} < bx + 11'(ALIEN_W)) &&
            ({1'b0, scan_y} >= by) && ({1'b0, scan_y} < by + 11'(ALIEN_H)))
          pixel_d = 1'b1;
      end
    end
  end

  // An alien is armed when nothing alive sits beneath it in its column.
  always_comb begin
    logic below;
    below        = 1'b0;
    armed_matrix = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      below = 1'b0;
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
        armed_matrix[r][c] = alive_q[r][c] & ~below;
        below = below | alive_q[r][c];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = MARCH;
    end else begin
      case (state_q)
        MARCH: begin
          if (alive_cnt == '0)                          state_d = CLEARED;
          else if (move_fire && step_down && invade_now) state_d = INVADED;
        end
        CLEARED: state_d = CLEARED;
        INVADED: state_d = INVADED;
        default: state_d = MARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= MARCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alive_q     <= '1;
      origin_x_q  <= 11'(START_X);
      origin_y_q  <= 11'(START_Y);
      dir_right_q <= 1'b1;
      level_q     <= '0;
      frame_cnt_q <= '0;
      hit_ack     <= 1'b0;
      hit_miss    <= 1'b0;
      hit_row     <= '0;
      hit_col     <= '0;
      alien_pixel <= 1'b0;
    end else begin
      hit_ack     <= 1'b0;
      hit_miss    <= 1'b0;
      alien_pixel <= pixel_d;
      if (restart) begin
        alive_q     <= '1;
        origin_x_q  <= 11'(START_X);
        origin_y_q  <= 11'(START_Y);
        dir_right_q <= 1'b1;
        frame_cnt_q <= '0;
        level_q     <= (level_q == 4'd15) ? level_q : level_q + 4'd1;
        hit_miss    <= hit_valid;
      end else begin
        if (hit_valid) begin
          if (hit_take) begin
            hit_ack <= 1'b1;
            hit_row <= hit_r_d;
            hit_col <= hit_c_d;
          end else begin
            hit_miss <= 1'b1;
          end
        end
        if (hit_take) alive_q <= alive_q & ~hit_mask;
        if (frame_tick && marching) begin
          if (move_fire) begin
            frame_cnt_q <= '0;
            if (step_down) begin
              origin_y_q  <= down_y;
              dir_right_q <= ~dir_right_q;
            end else if (dir_right_q) begin
              origin_x_q <= origin_x_q + 11'(STEP_X);
            end else begin
              origin_x_q <= origin_x_q - 11'(STEP_X);
            end
          end else begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
      end
    end
  end

  assign alive_matrix = alive_q;
  assign origin_x     = origin_x_q[9:0];
  assign origin_y     = origin_y_q[9:0];
  assign alive_count  = alive_cnt;
  assign level        = level_q;
  assign wave_cleared = (state_q == CLEARED);
  assign invaded      = (state_q == INVADED);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_alien_swarm.sv
// Directed bench for alien_swarm: reset state, hit/pixel vector table, march timing,
// bound step-downs, invasion, wave clear and restart.
module tb_alien_swarm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  scan_x = '0, scan_y = '0;
  logic        hit_valid = 1'b0;
  logic [9:0]  hit_x = '0, hit_y = '0;
  logic        restart = 1'b0;
  logic [2:0][4:0] alive_matrix, armed_matrix;
  logic [9:0]  origin_x, origin_y;
  logic [3:0]  alive_count;
  logic [3:0]  level;
  logic        hit_ack, hit_miss;
  logic [2:0]  hit_row;
  logic [3:0]  hit_col;
  logic        wave_cleared, invaded, alien_pixel;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q[$];

  typedef struct {
    logic       hit;
    logic [9:0] x;
    logic [9:0] y;
    logic       ack;
    logic       miss;
    logic [2:0] row;
    logic [3:0] col;
    int         cnt;
    logic       pix;
  } vec_t;
  vec_t vecs[14];

  alien_swarm #(.INVADE_Y(150)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .scan_x(scan_x), .scan_y(scan_y),
    .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
    .restart(restart),
    .alive_matrix(alive_matrix), .armed_matrix(armed_matrix),
    .origin_x(origin_x), .origin_y(origin_y),
    .alive_count(alive_count), .level(level),
    .hit_ack(hit_ack), .hit_miss(hit_miss),
    .hit_row(hit_row), .hit_col(hit_col),
    .wave_cleared(wave_cleared), .invaded(invaded),
    .alien_pixel(alien_pixel), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Scoreboard check
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drivers
  task automatic tick_n(input int n);
    @(negedge clk); frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_hit(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk); hit_valid = 1'b1; hit_x = x; hit_y = y;
    @(negedge clk); hit_valid = 1'b0;
  endtask

  task automatic check_origin(input string name, input int ex, input int ey);
    check({name, "_x"}, 32'(origin_x), 32'(ex));
    check({name, "_y"}, 32'(origin_y), 32'(ey));
  endtask

  task automatic check_reset(input string name);
    check({name, "_alive"}, 32'(alive_matrix), 32'h7fff);
    check({name, "_armed"}, 32'(armed_matrix), 32'h7c00);
    check_origin(name, 100, 50);
    check({name, "_count"}, 32'(alive_count), 32'd15);
    check({name, "_level"}, 32'(level), 32'd0);
    check({name, "_pulses"}, 32'({hit_ack, hit_miss}), 32'd0);
    check({name, "_status"}, 32'({wave_cleared, invaded}), 32'd0);
    check({name, "_pixel"}, 32'(alien_pixel), 32'd0);
    check({name, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  initial begin
    // Origin (100,50): col c spans x [100+64c, +32), row r spans y [50+32r, +16).
    vecs[0]  = '{1'b1, 10'd233, 10'd85,  1'b1, 1'b0, 3'd1, 4'd2, 14, 1'b1};
    vecs[1]  = '{1'b1, 10'd90,  10'd40,  1'b0, 1'b1, 3'd0, 4'd0, 14, 1'b0};
    vecs[2]  = '{1'b1, 10'd233, 10'd85,  1'b0, 1'b1, 3'd0, 4'd0, 14, 1'b0};
    vecs[3]  = '{1'b1, 10'd100, 10'd50,  1'b1, 1'b0, 3'd0, 4'd0, 13, 1'b1};
    vecs[4]  = '{1'b1, 10'd164, 10'd129, 1'b1, 1'b0, 3'd2, 4'd1, 12, 1'b1};
    vecs[5]  = '{1'b1, 10'd196, 10'd114, 1'b0, 1'b1, 3'd0, 4'd0, 12, 1'b0};
    vecs[6]  = '{1'b1, 10'd387, 10'd129, 1'b1, 1'b0, 3'd2, 4'd4, 11, 1'b1};
    vecs[7]  = '{1'b0, 10'd259, 10'd114, 1'b0, 1'b0, 3'd0, 4'd0, 11, 1'b1};
    vecs[8]  = '{1'b0, 10'd260, 10'd114, 1'b0, 1'b0, 3'd0, 4'd0, 11, 1'b0};
    vecs[9]  = '{1'b0, 10'd164, 10'd50,  1'b0, 1'b0, 3'd0, 4'd0, 11, 1'b1};
    vecs[10] = '{1'b0, 10'd100, 10'd65,  1'b0, 1'b0, 3'd0, 4'd0, 11, 1'b0};
    vecs[11] = '{1'b0, 10'd387, 10'd97,  1'b0, 1'b0, 3'd0, 4'd0, 11, 1'b1};
    vecs[12] = '{1'b0, 10'd388, 10'd97,  1'b0, 1'b0, 3'd0, 4'd0, 11, 1'b0};
    vecs[13] = '{1'b1, 10'd164, 10'd98,  1'b0, 1'b1, 3'd0, 4'd0, 11, 1'b0};

    do_rst();
    check_reset("reset");

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      hit_valid = vecs[i].hit;
      hit_x = vecs[i].x; hit_y = vecs[i].y;
      scan_x = vecs[i].x; scan_y = vecs[i].y;
      @(negedge clk);
      hit_valid = 1'b0;
      check($sformatf("vec%0d_ack", i), 32'(hit_ack), 32'(vecs[i].ack));
      check($sformatf("vec%0d_miss", i), 32'(hit_miss), 32'(vecs[i].miss));
      if (vecs[i].ack) check($sformatf("vec%0d_idx", i), 32'({hit_row, hit_col}),
                             32'({vecs[i].row, vecs[i].col}));
      check($sformatf("vec%0d_count", i), 32'(alive_count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_pixel", i), 32'(alien_pixel), 32'(vecs[i].pix));
    end
    check("table_alive", 32'(alive_matrix), 32'(15'b01101_11011_11110));
    check("table_armed", 32'(armed_matrix), 32'(15'b01101_10010_00000));
    scan_x = '0; scan_y = '0;

    // Full-strength march: period 60 frames per move.
    do_rst();
    tick_n(59);
    check_origin("no_early_move", 100, 50);
    tick_n(1);
    check_origin("first_move", 104, 50);
    tick_n(58 * 60);
    check_origin("move59", 336, 50);
    tick_n(60);
    check_origin("right_stepdown", 336, 66);
    check("no_invade_yet", 32'(invaded), 32'd0);
    tick_n(60);
    check_origin("left_move", 332, 66);
    tick_n(79 * 60);
    check_origin("left_edge", 16, 66);
    tick_n(60);
    check_origin("left_stepdown", 16, 82);
    check("invaded", 32'(invaded), 32'd1);
    check("invaded_state", 32'(state_dbg), 32'd2);
    tick_n(200);
    check_origin("invaded_frozen", 16, 82);
    do_hit(10'd20, 10'd90);
    check("invaded_hit_miss", 32'({hit_ack, hit_miss}), 32'd1);
    check("invaded_count", 32'(alive_count), 32'd15);

    // rst mid-march beats a simultaneous hit and tick.
    do_rst();
    tick_n(30);
    @(negedge clk);
    rst = 1'b1; frame_tick = 1'b1; hit_valid = 1'b1; hit_x = 10'd100; hit_y = 10'd50;
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0; hit_valid = 1'b0;
    check_reset("mid_rst");
    tick_n(59);
    check_origin("mid_rst_cnt_clear", 100, 50);
    tick_n(1);
    check_origin("mid_rst_first_move", 104, 50);

    // Column 4 destroyed: period 54 and right bound uses column 3.
    do_rst();
    for (int r = 0; r < 3; r++) begin
      do_hit(10'd356, 10'(50 + 32 * r));
      check($sformatf("col4_r%0d_ack", r), 32'(hit_ack), 32'd1);
      check($sformatf("col4_r%0d_idx", r), 32'({hit_row, hit_col}), 32'({3'(r), 4'd4}));
    end
    check("col4_alive", 32'(alive_matrix), 32'(15'b01111_01111_01111));
    check("col4_count", 32'(alive_count), 32'd12);
    tick_n(53);
    check_origin("p54_no_early", 100, 50);
    tick_n(1);
    check_origin("p54_move", 104, 50);
    tick_n(73 * 54);
    check_origin("col4_396", 396, 50);
    tick_n(54);
    check_origin("col4_400", 400, 50);
    tick_n(54);
    check_origin("col4_stepdown", 400, 66);

    // Kill the remaining twelve at origin (400,66).
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        exp_q.push_back({3'(r), 4'(c)});
        do_hit(10'(401 + 64 * c), 10'(67 + 32 * r));
        check("kill_ack", 32'(hit_ack), 32'd1);
        check("kill_idx", 32'({hit_row, hit_col}), 32'(exp_q.pop_front()));
        check("kill_count", 32'(alive_count), 32'(11 - (r * 4 + c)));
      end
    end
    check("cleared_not_yet", 32'(wave_cleared), 32'd0);
    @(negedge clk);
    check("wave_cleared", 32'(wave_cleared), 32'd1);
    check("cleared_state", 32'(state_dbg), 32'd1);
    tick_n(200);
    check_origin("cleared_frozen", 400, 66);

    // restart together with a hit on an alien box: restart wins, hit misses.
    @(negedge clk);
    restart = 1'b1; hit_valid = 1'b1; hit_x = 10'd100; hit_y = 10'd50;
    @(negedge clk);
    restart = 1'b0; hit_valid = 1'b0;
    check("restart_miss", 32'({hit_ack, hit_miss}), 32'd1);
    check("restart_level", 32'(level), 32'd1);
    check("restart_alive", 32'(alive_matrix), 32'h7fff);
    check("restart_count", 32'(alive_count), 32'd15);
    check_origin("restart", 100, 50);
    check("restart_status", 32'({wave_cleared, invaded}), 32'd0);
    tick_n(51);
    check_origin("p52_no_early", 100, 50);
    tick_n(1);
    check_origin("p52_move", 104, 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
